// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a sticky, registered one-hot grant and handshake.
// The accepted requester becomes lowest priority for the next arbitration.
module rr_onehot_arb #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             flush,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic             w_accept;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_scan_start;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_req_hi;
  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic             w_lo_found;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_found;
  logic [IDX_W-1:0] w_win_idx;
  logic [N-1:0]     w_win_oh;

  assign w_accept  = (r_state == ST_HOLD) && gnt_ready;
  assign w_ptr_nxt = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);

  // Back-to-back arbitration must already see the advanced pointer.
  assign w_scan_start = (r_state == ST_HOLD) ? w_ptr_nxt : r_ptr;

  // Requests at or above the start position win first; otherwise wrap to the
  // lowest set request below it.
  always_comb begin
    w_mask     = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_mask[i] = (IDX_W'(i) >= w_scan_start);
    end
    w_req_hi = req & w_mask;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_hi_found && w_req_hi[i]) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IDX_W'(i);
      end
      if (!w_lo_found && req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_W'(i);
      end
    end
    w_found   = w_lo_found;
    w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    w_win_oh  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_win_oh[i] = w_found && (IDX_W'(i) == w_win_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_onehot <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_onehot <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_HOLD;
            r_onehot <= w_win_oh;
            r_idx    <= w_win_idx;
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_ptr <= w_ptr_nxt;
            if (w_found) begin
              r_onehot <= w_win_oh;
              r_idx    <= w_win_idx;
            end else begin
              r_state  <= ST_IDLE;
              r_onehot <= '0;
              r_idx    <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_onehot <= '0;
          r_idx    <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = (r_state == ST_HOLD);
  assign gnt_onehot = r_onehot;
  assign gnt_idx    = r_idx;
  assign ptr        = r_ptr;

endmodule
